// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth multiplier, signed/unsigned, one step per clock
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         r_state;
  logic [WIDTH:0] r_m;
  logic [WIDTH:0] r_acc;
  logic [WIDTH:0] r_q;
  logic           r_qm1;
  logic [CW-1:0]  r_cnt;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_acc;
  logic [WIDTH:0] w_q;
  logic           w_last;
  logic           w_accept;
  // one Booth step: add/subtract by {Q[0], q_m1}, then arithmetic shift of {ACC, Q, q_m1}
  always_comb begin
    w_sum    = (r_q[0] & ~r_qm1) ? r_acc - r_m : (~r_q[0] & r_qm1) ? r_acc + r_m : r_acc;
    w_acc    = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q      = {w_sum[0], r_q[WIDTH:1]};
    w_last   = r_cnt == CW'(WIDTH);
    w_accept = start & (r_state != CALC);
  end
  // FSM with operand capture, step iteration and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else if (w_accept) begin
      r_state <= CALC;
      r_m     <= {signed_mode & a[WIDTH-1], a};
      r_q     <= {signed_mode & b[WIDTH-1], b};
      r_acc   <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc;
      r_q   <= w_q;
      r_qm1 <= r_q[0];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_state <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        product <= {w_acc[WIDTH-2:0], w_q};
      end
    end else begin
      r_state <= IDLE;
      done    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: randomized and directed checks against a plain-arithmetic model
module tb_booth_seq_multiplier;
  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        rst_s = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          sweep_cnt = 0;
  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_pend = '0;

  booth_seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint ex, ey;
    ex = s ? longint'($signed(x)) : longint'(x);
    ey = s ? longint'($signed(y)) : longint'(y);
    return 16'(ex * ey);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // model: an accepted request finishes 9 edges later with the plain product
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_prod <= m_pend;
      if (m_rem > 0) m_rem <= m_rem - 1;
      else if (start) begin
        m_rem  <= 9;
        m_pend <= ref8(a, b, signed_mode);
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    total++;
    if ({busy, done, product} !== {m_rem != 0, m_done, m_prod}) begin
      bad++;
      $display("FAIL cycle t=%0t: busy/done/product got %b/%b/%h want %b/%b/%h",
               $time, busy, done, product, m_rem != 0, m_done, m_prod);
    end
  end

  task automatic run(input logic [15:0] exp, input string nm);
    int lat, bc;
    @(posedge clk); #1 start = 1'b0;
    bc = int'(busy);
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1 lat++;
      if (!done) bc += int'(busy);
    end
    chk({nm, " latency"}, 64'(lat), 64'd9);
    chk({nm, " busy cycles"}, 64'(bc), 64'd9);
    chk({nm, " product"}, 64'(product), 64'(exp));
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                    input logic [15:0] exp, input string nm);
    a = ta;
    b = tb;
    signed_mode = ts;
    start = 1'b1;
    run(exp, nm);
  endtask

  initial begin
    longint mask;
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", 64'(product), 64'd0);
    rst = 1'b0;
    rst_s = 1'b0;
    op(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s -3*5");
    op(8'h80, 8'h80, 1'b1, 16'h4000, "s -128*-128");
    op(8'h80, 8'h7F, 1'b1, 16'hC080, "s -128*127");
    op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u 255*255");
    op(8'h80, 8'h80, 1'b0, 16'h4000, "u 128*128");
    // start while busy must be ignored
    a = 8'd7; b = 8'd6; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    mask = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) mask |= longint'(1) << c;
      start = (c == 3);
      if (c == 3) begin a = 8'd2; b = 8'd2; end
    end
    chk("busy-start done cycles", 64'(mask), 64'h200);
    chk("busy-start product", 64'(product), 64'h002A);
    // back-to-back with start held high
    a = 8'd10; b = 8'd10; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 a = 8'hFF; b = 8'h01;
    mask = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 10) start = 1'b0;
      if (done) mask |= longint'(1) << c;
      if (c == 9) chk("b2b first product", 64'(product), 64'h0064);
      if (c == 19) chk("b2b second product", 64'(product), 64'h00FF);
    end
    chk("b2b done cycles", 64'(mask), 64'h80200);
    // reset in the middle of step 5, then start held across reset release
    a = 8'd7; b = 8'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid-reset busy", 64'(busy), 64'd0);
    chk("mid-reset done", 64'(done), 64'd0);
    chk("mid-reset product", 64'(product), 64'd0);
    a = 8'd3; b = 8'd3; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run(16'h0009, "post-reset 3*3");
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      op(ra, rb, rs, ref8(ra, rb, rs), $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 5000 && sweep_cnt < 3; i++) @(posedge clk);
    chk("sweeps finished", 64'(sweep_cnt), 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int WS = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    logic            s_start, s_sm, s_busy, s_done;
    logic [WS-1:0]   s_a, s_b;
    logic [2*WS-1:0] s_prod, s_exp;

    booth_seq_multiplier #(.WIDTH(WS)) dut (
      .clk(clk), .rst(rst_s), .start(s_start), .signed_mode(s_sm),
      .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .product(s_prod)
    );

    function automatic logic [WS-1:0] pick(input int k);
      logic [WS-1:0] v;
      v = '0;
      if (k == 1) v = '1;
      else if (k == 2) begin
        v = '1;
        v[WS-1] = 1'b0;
      end else if (k == 3) v[WS-1] = 1'b1;
      return v;
    endfunction

    initial begin
      int lat;
      longint ea, eb;
      s_start = 1'b0;
      s_sm = 1'b0;
      s_a = '0;
      s_b = '0;
      wait (rst_s == 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
        if (i < 16) begin
          s_a = pick(i % 4);
          s_b = pick(i / 4);
          s_sm = i[0] ^ i[2];
        end else begin
          s_a = WS'($urandom);
          s_b = WS'($urandom);
          s_sm = 1'($urandom);
        end
        ea = s_sm ? longint'($signed(s_a)) : longint'(s_a);
        eb = s_sm ? longint'($signed(s_b)) : longint'(s_b);
        s_exp = (2*WS)'(ea * eb);
        s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        lat = 0;
        while (!s_done && lat < 100) begin
          @(posedge clk); #1 lat++;
        end
        chk($sformatf("w%0d op%0d latency", WS, i), 64'(lat), 64'(WS + 1));
        chk($sformatf("w%0d op%0d product", WS, i), 64'(s_prod), 64'(s_exp));
      end
      sweep_cnt++;
    end
  end
endmodule
